// File: rtl/simple_st0_error_tap_buffer_pkg.sv
// rtl/simple_st0_error_tap_buffer_pkg.sv - shared stage-0 error types and tap/phase constants
// Used by the error FIFO controller and the tap buffer.
package simple_st0_error_tap_buffer_pkg;

    localparam int ST0_TAPS   = 6;
    localparam int ST0_PHASES = 4;

    typedef logic [31:0] float_24_8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } replay_state_e;

endpackage

// File: rtl/simple_st0_error_tap_ram.sv
// rtl/simple_st0_error_tap_ram.sv - flop-array error store, one write port, one combinational read port
// Contents are not reset; the phase flags in the top decide what is meaningful.
module simple_st0_error_tap_ram #(
    parameter int DEPTH  = 24,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/simple_st0_error_tap_buffer.sv
// rtl/simple_st0_error_tap_buffer.sv - 4-phase x 6-tap error store replayed as a tap-error stream
// Optional sticky overflow/underrun status under `ST0_ERROR_TAP_STATUS_EN.
module simple_st0_error_tap_buffer
    import simple_st0_error_tap_buffer_pkg::*;
#(
    parameter int TAPS   = ST0_TAPS,
    parameter int PHASES = ST0_PHASES,
    parameter int WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       error_valid,
    input  logic [WIDTH-1:0]           error_value,
    input  logic [$clog2(PHASES)-1:0]  error_phase,
    input  logic [31:0]                error_sub_address,
    input  logic                       stage_error_mode,
    input  logic                       stage_error_first,
    input  logic                       tap_error_rdy,
    output logic                       tap_error_vld,
    output logic [WIDTH-1:0]           tap_error,
    output logic                       tap_error_fst,
    output logic                       tap_error_lst,
    output logic [PHASES-1:0]          phase_valid,
    output logic                       replay_busy,
    output logic                       buffer_overflow,
    output logic                       buffer_underrun
);

    localparam int DEPTH  = PHASES * TAPS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PH_W   = $clog2(PHASES);
    localparam int TAP_W  = $clog2(TAPS);

    replay_state_e     state_q, state_d;
    logic [PH_W-1:0]   rd_phase_q, rd_phase_d;
    logic [TAP_W-1:0]  rd_tap_q, rd_tap_d;
    logic [PHASES-1:0] phase_valid_q, phase_valid_d;
    logic [WIDTH-1:0]  tap_error_q, tap_error_d;
    logic              vld_q, vld_d;
    logic              fst_q, fst_d;
    logic              lst_q, lst_d;

    logic              wr_legal;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic [TAP_W-1:0]  tap_next;
    logic              start_req;
    logic              start_ok;
    logic              hs;
    logic [PHASES-1:0] phase_set;
    logic [PHASES-1:0] phase_clr;

    // A full, unread phase is write-protected until its replay completes.
    assign wr_legal = error_sub_address < 32'(TAPS);
    assign wr_en    = error_valid & wr_legal & ~phase_valid_q[error_phase];
    assign wr_addr  = ADDR_W'(error_phase) * ADDR_W'(TAPS) + ADDR_W'(error_sub_address);

    // Read address looks one word ahead so the output register loads the next tap.
    assign tap_next  = (state_q == ST_IDLE) ? '0 : rd_tap_q + TAP_W'(1);
    assign rd_addr   = ADDR_W'(rd_phase_q) * ADDR_W'(TAPS) + ADDR_W'(tap_next);

    assign start_req = stage_error_first & stage_error_mode & (state_q == ST_IDLE);
    assign start_ok  = start_req & phase_valid_q[rd_phase_q];
    assign hs        = vld_q & tap_error_rdy;

    simple_st0_error_tap_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (error_value),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        rd_phase_d  = rd_phase_q;
        rd_tap_d    = rd_tap_q;
        tap_error_d = tap_error_q;
        vld_d       = vld_q;
        fst_d       = fst_q;
        lst_d       = lst_q;
        phase_clr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d     = ST_STREAM;
                    rd_tap_d    = '0;
                    tap_error_d = rd_data;
                    vld_d       = 1'b1;
                    fst_d       = 1'b1;
                    lst_d       = (TAPS == 1);
                end
            end
            ST_STREAM: begin
                if (hs) begin
                    if (lst_q) begin
                        phase_clr[rd_phase_q] = 1'b1;
                        rd_phase_d = (rd_phase_q == PH_W'(PHASES - 1)) ? '0 : rd_phase_q + PH_W'(1);
                        state_d    = ST_IDLE;
                        vld_d      = 1'b0;
                        fst_d      = 1'b0;
                        lst_d      = 1'b0;
                    end else begin
                        rd_tap_d    = tap_next;
                        tap_error_d = rd_data;
                        fst_d       = 1'b0;
                        lst_d       = (tap_next == TAP_W'(TAPS - 1));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set and clear may target different phases in the same cycle; both apply.
    always_comb begin
        phase_set = '0;
        if (wr_en && (error_sub_address == 32'(TAPS - 1))) begin
            phase_set[error_phase] = 1'b1;
        end
        phase_valid_d = (phase_valid_q & ~phase_clr) | phase_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rd_phase_q    <= '0;
            rd_tap_q      <= '0;
            phase_valid_q <= '0;
            tap_error_q   <= '0;
            vld_q         <= 1'b0;
            fst_q         <= 1'b0;
            lst_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_phase_q    <= rd_phase_d;
            rd_tap_q      <= rd_tap_d;
            phase_valid_q <= phase_valid_d;
            tap_error_q   <= tap_error_d;
            vld_q         <= vld_d;
            fst_q         <= fst_d;
            lst_q         <= lst_d;
        end
    end

    assign tap_error_vld = vld_q;
    assign tap_error     = tap_error_q;
    assign tap_error_fst = fst_q;
    assign tap_error_lst = lst_q;
    assign phase_valid   = phase_valid_q;
    assign replay_busy   = (state_q == ST_STREAM);

`ifdef ST0_ERROR_TAP_STATUS_EN
    logic wr_drop;
    logic underrun_evt;
    logic overflow_q, overflow_d;
    logic underrun_q, underrun_d;

    assign wr_drop      = error_valid & wr_legal & phase_valid_q[error_phase];
    assign underrun_evt = start_req & ~phase_valid_q[rd_phase_q];

    always_comb begin
        overflow_d = overflow_q | wr_drop;
        underrun_d = underrun_q | underrun_evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign buffer_overflow = overflow_q;
    assign buffer_underrun = underrun_q;
`else
    assign buffer_overflow = 1'b0;
    assign buffer_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_simple_st0_error_tap_buffer.sv
// tb/tb_simple_st0_error_tap_buffer.sv - self-checking bench for the stage-0 error tap buffer
// Scoreboard queue filled at replay start from a bench-side memory model, drained by a monitor.
module tb_simple_st0_error_tap_buffer;

`ifdef ST0_ERROR_TAP_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        error_valid;
    logic [31:0] error_value;
    logic [1:0]  error_phase;
    logic [31:0] error_sub_address;
    logic        stage_error_mode;
    logic        stage_error_first;
    logic        tap_error_rdy;
    logic        tap_error_vld;
    logic [31:0] tap_error;
    logic        tap_error_fst;
    logic        tap_error_lst;
    logic [3:0]  phase_valid;
    logic        replay_busy;
    logic        buffer_overflow;
    logic        buffer_underrun;

    always #5 clk = ~clk;

    simple_st0_error_tap_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .error_valid       (error_valid),
        .error_value       (error_value),
        .error_phase       (error_phase),
        .error_sub_address (error_sub_address),
        .stage_error_mode  (stage_error_mode),
        .stage_error_first (stage_error_first),
        .tap_error_rdy     (tap_error_rdy),
        .tap_error_vld     (tap_error_vld),
        .tap_error         (tap_error),
        .tap_error_fst     (tap_error_fst),
        .tap_error_lst     (tap_error_lst),
        .phase_valid       (phase_valid),
        .replay_busy       (replay_busy),
        .buffer_overflow   (buffer_overflow),
        .buffer_underrun   (buffer_underrun)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        fst;
        logic        lst;
    } exp_t;

    typedef struct {
        int         rdy_mode;
        logic [3:0] exp_pv;
        logic [1:0] exp_rd;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    int          hs_count;
    exp_t        sb_q[$];
    logic [31:0] mdl_mem [4][6];
    logic [3:0]  mdl_pv;
    int          mdl_rd;
    logic        mdl_ovf;
    logic        mdl_unr;
    vec_t        vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks hold-under-backpressure.
    initial begin
        logic        stall_prev;
        logic [31:0] stall_data;
        logic [1:0]  stall_fl;
        exp_t        e;
        stall_prev = 1'b0;
        stall_data = '0;
        stall_fl   = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_vld", {31'd0, tap_error_vld}, 32'd1);
                    check("hold_data", tap_error, stall_data);
                    check("hold_fst_lst", {30'd0, tap_error_fst, tap_error_lst}, {30'd0, stall_fl});
                end
                if (tap_error_vld && tap_error_rdy) begin
                    hs_count++;
                    if (sb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_word: got %h with empty scoreboard", tap_error);
                    end else begin
                        e = sb_q.pop_front();
                        check("word_data", tap_error, e.data);
                        check("word_fst_lst", {30'd0, tap_error_fst, tap_error_lst}, {30'd0, e.fst, e.lst});
                    end
                end
                stall_prev = tap_error_vld && !tap_error_rdy;
                stall_data = tap_error;
                stall_fl   = {tap_error_fst, tap_error_lst};
            end
        end
    end

    task automatic write_word(input int p, input int sub, input logic [31:0] v);
        error_valid       = 1'b1;
        error_phase       = p[1:0];
        error_sub_address = sub;
        error_value       = v;
        if (sub < 6) begin
            if (!mdl_pv[p]) begin
                mdl_mem[p][sub] = v;
                if (sub == 5) mdl_pv[p] = 1'b1;
            end else if (STATUS) begin
                mdl_ovf = 1'b1;
            end
        end
        tick();
        error_valid = 1'b0;
    endtask

    task automatic fill(input int p, input logic [31:0] base);
        for (int i = 0; i < 6; i++) write_word(p, i, base + i);
    endtask

    task automatic start_pulse();
        exp_t e;
        stage_error_first = 1'b1;
        stage_error_mode  = 1'b1;
        hs_count = 0;
        if (mdl_pv[mdl_rd]) begin
            for (int i = 0; i < 6; i++) begin
                e.data = mdl_mem[mdl_rd][i];
                e.fst  = (i == 0);
                e.lst  = (i == 5);
                sb_q.push_back(e);
            end
        end else if (STATUS) begin
            mdl_unr = 1'b1;
        end
        tick();
        stage_error_first = 1'b0;
        stage_error_mode  = 1'b0;
    endtask

    task automatic replay(input int mode);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int cyc = 0;
        start_pulse();
        check("start_vld_fst", {30'd0, tap_error_vld, tap_error_fst}, 32'd3);
        while (sb_q.size() != 0 && cyc < 100) begin
            tap_error_rdy = (mode == 0) ? 1'b1 : pat[cyc % 4];
            tick();
            cyc++;
        end
        tap_error_rdy = 1'b0;
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d words left, required 0", sb_q.size());
            sb_q.delete();
        end
        mdl_pv[mdl_rd] = 1'b0;
        mdl_rd = (mdl_rd + 1) % 4;
        check("handshakes", hs_count, 32'd6);
        check("end_vld_busy", {30'd0, tap_error_vld, replay_busy}, 32'd0);
        check("end_phase_valid", {28'd0, phase_valid}, {28'd0, mdl_pv});
        check("end_rd_phase", {30'd0, dut.rd_phase_q}, mdl_rd);
    endtask

    initial begin
        reset             = 1'b0;
        error_valid       = 1'b0;
        error_value       = '0;
        error_phase       = '0;
        error_sub_address = '0;
        stage_error_mode  = 1'b0;
        stage_error_first = 1'b0;
        tap_error_rdy     = 1'b0;
        mdl_pv  = '0;
        mdl_rd  = 0;
        mdl_ovf = 1'b0;
        mdl_unr = 1'b0;
        vecs[0] = '{0, 4'b1110, 2'd1};
        vecs[1] = '{1, 4'b1100, 2'd2};
        vecs[2] = '{0, 4'b1000, 2'd3};
        vecs[3] = '{1, 4'b0000, 2'd0};

        tick();
        tick();
        check("rst_outputs", {25'd0, tap_error_vld, tap_error_fst, tap_error_lst, replay_busy,
              buffer_overflow, buffer_underrun, 1'b0}, 32'd0);
        check("rst_phase_valid", {28'd0, phase_valid}, 32'd0);
        check("rst_tap_error", tap_error, 32'd0);
        reset = 1'b1;
        tick();

        // Out-of-range sub-addresses must neither write nor set a flag.
        write_word(0, 6, 32'hDEAD_0006);
        write_word(0, 100, 32'hDEAD_0064);
        check("oob_no_flag", {28'd0, phase_valid}, 32'd0);

        fill(0, 32'h3F80_0000);
        check("fill0_pv", {28'd0, phase_valid}, 32'd1);
        replay(0);

        fill(1, 32'h3F90_0000);
        replay(1);

        // Start against empty phase 2.
        start_pulse();
        tick();
        check("underrun_no_vld", {30'd0, tap_error_vld, replay_busy}, 32'd0);
        check("underrun_rd_phase", {30'd0, dut.rd_phase_q}, 32'd2);
        check("underrun_flag", {31'd0, buffer_underrun}, {31'd0, mdl_unr});

        // Rewrite of a full phase is dropped; replay yields the original data.
        fill(2, 32'h4000_0000);
        fill(2, 32'hC000_0000);
        check("overflow_flag", {31'd0, buffer_overflow}, {31'd0, mdl_ovf});
        replay(0);

        // Reset in the middle of a replay while tap 3 is presented.
        fill(3, 32'h4040_0000);
        start_pulse();
        tap_error_rdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tap_error_rdy = 1'b0;
        check("mid_tap3", tap_error, mdl_mem[3][3]);
        reset = 1'b0;
        #1;
        check("mid_rst_outputs", {27'd0, tap_error_vld, tap_error_fst, tap_error_lst, replay_busy, 1'b0},
              32'd0);
        check("mid_rst_pv", {28'd0, phase_valid}, 32'd0);
        sb_q.delete();
        mdl_pv  = '0;
        mdl_rd  = 0;
        mdl_ovf = 1'b0;
        mdl_unr = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_status", {30'd0, buffer_overflow, buffer_underrun}, 32'd0);

        // Fill every phase, then consume in order with wrap of rd_phase.
        for (int p = 0; p < 4; p++) fill(p, 32'h4100_0000 + 32'(p * 16));
        check("fill_all_pv", {28'd0, phase_valid}, 32'hF);
        for (int v = 0; v < 4; v++) begin
            replay(vecs[v].rdy_mode);
            check("vec_pv", {28'd0, phase_valid}, {28'd0, vecs[v].exp_pv});
            check("vec_rd", {30'd0, dut.rd_phase_q}, {30'd0, vecs[v].exp_rd});
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
